// File: rtl/packetizer.sv
// Transmit framer: registers one payload, then streams a length/stream header word, a
// per-stream sequence word and the payload words over a valid/ready/last handshake.
module packetizer #(
  parameter int unsigned MAX_BYTES = 37,
  parameter int unsigned STREAMS   = 32
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [0:8*MAX_BYTES-1]   payloadIn,
  input  logic [5:0]               payloadLen,
  input  logic [15:0]              streamId,
  input  logic                     payloadIn_val,
  output logic                     payloadIn_ready,
  output logic [31:0]              dataOut,
  output logic                     dataOut_val,
  input  logic                     dataOut_ready,
  output logic                     dataOut_last,
  output logic                     lenError
);

  localparam int unsigned MaxWords = (MAX_BYTES + 3) / 4;
  localparam int unsigned PadBytes = 4 * MaxWords;
  localparam int unsigned IdxW     = $clog2(MaxWords + 1);
  localparam int unsigned SidW     = $clog2(STREAMS);

  typedef enum logic [1:0] {StIdle, StHdr, StSeq, StData} state_e;

  state_e                 state_q, state_d;
  logic [0:8*PadBytes-1]  pay_q, pay_d;
  logic [31:0]            seq_q, seq_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        w_q, w_d;
  logic [31:0]            data_q, data_d;
  logic                   val_q, val_d;
  logic                   last_q, last_d;
  logic                   rdy_q, rdy_d;
  logic                   lerr_q, lerr_d;
  logic [31:0]            seq_tab_q [STREAMS];
  logic [31:0]            seq_tab_d [STREAMS];

  logic                   accept;
  logic                   len_ok;
  logic [SidW-1:0]        sid;
  logic [31:0]            seq_next;
  logic [IdxW-1:0]        words_in;
  logic [0:8*PadBytes-1]  pay_masked;
  logic [IdxW-1:0]        sel_idx;
  logic [31:0]            word_nxt;

  assign accept   = payloadIn_val && rdy_q;
  assign len_ok   = (payloadLen != 6'd0) && (32'(payloadLen) <= MAX_BYTES);
  assign sid      = streamId[SidW-1:0];
  assign seq_next = seq_tab_q[sid] + 32'd1;
  assign words_in = IdxW'((32'(payloadLen) + 32'd3) >> 2);

  // Bytes past the length are zeroed on capture so the last word needs no masking later.
  always_comb begin
    pay_masked = '0;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (k < int'(payloadLen)) begin
        pay_masked[8*k +: 8] = payloadIn[8*k +: 8];
      end
    end
  end

  assign sel_idx = (state_q == StSeq) ? '0 : idx_q + IdxW'(1);

  always_comb begin
    word_nxt = '0;
    for (int j = 0; j < int'(MaxWords); j++) begin
      if (IdxW'(j) == sel_idx) begin
        word_nxt = pay_q[32*j +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pay_d     = pay_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    w_d       = w_q;
    data_d    = data_q;
    val_d     = val_q;
    last_d    = last_q;
    rdy_d     = rdy_q;
    lerr_d    = 1'b0;
    seq_tab_d = seq_tab_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (len_ok) begin
            state_d        = StHdr;
            pay_d          = pay_masked;
            seq_d          = seq_next;
            seq_tab_d[sid] = seq_next;
            w_d            = words_in;
            idx_d          = '0;
            data_d         = {16'(payloadLen) + 16'd8, streamId};
            val_d          = 1'b1;
            last_d         = 1'b0;
            rdy_d          = 1'b0;
          end else begin
            lerr_d = 1'b1;
          end
        end
      end
      StHdr: begin
        if (dataOut_ready) begin
          state_d = StSeq;
          data_d  = seq_q;
        end
      end
      StSeq: begin
        if (dataOut_ready) begin
          state_d = StData;
          idx_d   = '0;
          data_d  = word_nxt;
          last_d  = (w_q == IdxW'(1));
        end
      end
      StData: begin
        if (dataOut_ready) begin
          if (idx_q == w_q - IdxW'(1)) begin
            state_d = StIdle;
            data_d  = '0;
            val_d   = 1'b0;
            last_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            idx_d  = idx_q + IdxW'(1);
            data_d = word_nxt;
            last_d = (idx_q + IdxW'(2) == w_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
      pay_q   <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b1;
      lerr_q  <= 1'b0;
      for (int i = 0; i < int'(STREAMS); i++) begin
        seq_tab_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      data_q  <= data_d;
      val_q   <= val_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      lerr_q  <= lerr_d;
      for (int i = 0; i < int'(STREAMS); i++) begin
        seq_tab_q[i] <= seq_tab_d[i];
      end
    end
  end

  assign payloadIn_ready = rdy_q;
  assign dataOut         = data_q;
  assign dataOut_val     = val_q;
  assign dataOut_last    = last_q;
  assign lenError        = lerr_q;

endmodule
